// File: rtl/bcd_clock_hms.sv
// bcd_clock_hms
//   BCD time-of-day counter with an internal seconds prescaler, a run-time
//   12/24-hour display mode, a validated time-load port and a latched
//   minute alarm. The hour is kept internally in 24-hour BCD; the 12-hour
//   view is derived combinationally so switching modes never disturbs the
//   count.
//
// Parameters
//   DIV     ena-qualified cycles per one-second advance (1..2^24)
//   DIV_W   prescaler width, 2^DIV_W >= DIV
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ena               prescaler count enable
//   mode24            1 = 24-hour display, 0 = 12-hour display with pm
//   set_en            one-cycle time-load strobe
//   set_hh/mm/ss      load value, BCD, in the current display mode
//   set_pm            PM flag for 12-hour loads
//   alm_set           alarm-load strobe
//   alm_hh/alm_mm     alarm time, BCD, always 24-hour
//   alm_arm           alarm enable (level)
//   alm_ack           clears a latched alarm
//   hh/mm/ss          displayed time, BCD
//   pm                internal hour is 12..23
//   tick_1s           one-cycle pulse with every seconds advance
//   alarm             latched alarm
//   set_err           one-cycle pulse when a time or alarm load is rejected
module bcd_clock_hms #(
    parameter int unsigned DIV   = 1,
    parameter int unsigned DIV_W = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       mode24,
    input  logic       set_en,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       set_pm,
    input  logic       alm_set,
    input  logic [7:0] alm_hh,
    input  logic [7:0] alm_mm,
    input  logic       alm_arm,
    input  logic       alm_ack,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       pm,
    output logic       tick_1s,
    output logic       alarm,
    output logic       set_err
);

    localparam logic [DIV_W-1:0] PC_MAX = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------
    function automatic logic is_bcd(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Returns {wrap, next}; wrap is set when v was at max and rolled to 00.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 9'h100;
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD v - 12 for v in 13..23, borrowing across the digit boundary.
    function automatic logic [7:0] bcd_sub12(input logic [7:0] v);
        if (v[3:0] >= 4'd2)
            return {v[7:4] - 4'd1, v[3:0] - 4'd2};
        else
            return {v[7:4] - 4'd2, v[3:0] + 4'd8};
    endfunction

    // BCD v + 12 for v in 01..11, carrying across the digit boundary.
    function automatic logic [7:0] bcd_add12(input logic [7:0] v);
        if (v[3:0] >= 4'd8)
            return {v[7:4] + 4'd2, v[3:0] - 4'd8};
        else
            return {v[7:4] + 4'd1, v[3:0] + 4'd2};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] pc_q,    pc_d;
    logic [7:0]       h24_q,   h24_d;
    logic [7:0]       m_q,     m_d;
    logic [7:0]       s_q,     s_d;
    logic [7:0]       ah_q,    ah_d;
    logic [7:0]       am_q,    am_d;
    logic             alarm_q, alarm_d;
    logic             tick_q,  tick_d;
    logic             err_q,   err_d;

    // ------------------------------------------------------------------
    // One-second successor of the current time
    // ------------------------------------------------------------------
    logic [8:0] s_inc, m_inc, h_inc;
    logic [7:0] s_adv, m_adv, h_adv;

    always_comb begin
        s_inc = bcd_inc(s_q, 8'h59);
        m_inc = bcd_inc(m_q, 8'h59);
        h_inc = bcd_inc(h24_q, 8'h23);
        s_adv = s_inc[7:0];
        m_adv = s_inc[8] ? m_inc[7:0] : m_q;
        h_adv = (s_inc[8] && m_inc[8]) ? h_inc[7:0] : h24_q;
    end

    // ------------------------------------------------------------------
    // Load validation and 12-hour to 24-hour conversion
    // ------------------------------------------------------------------
    logic       set_ok;
    logic       alm_ok;
    logic [7:0] h24_load;

    always_comb begin
        set_ok = is_bcd(set_hh) && is_bcd(set_mm) && is_bcd(set_ss)
                 && (set_mm <= 8'h59) && (set_ss <= 8'h59);
        if (mode24)
            set_ok = set_ok && (set_hh <= 8'h23);
        else
            set_ok = set_ok && (set_hh >= 8'h01) && (set_hh <= 8'h12);

        alm_ok = is_bcd(alm_hh) && is_bcd(alm_mm)
                 && (alm_hh <= 8'h23) && (alm_mm <= 8'h59);

        // 12 AM is hour 00, 12 PM is hour 12, other PM hours shift by 12.
        if (mode24)
            h24_load = set_hh;
        else if (set_hh == 8'h12)
            h24_load = set_pm ? 8'h12 : 8'h00;
        else if (set_pm)
            h24_load = bcd_add12(set_hh);
        else
            h24_load = set_hh;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic adv;
    logic match;

    always_comb begin
        pc_d    = pc_q;
        h24_d   = h24_q;
        m_d     = m_q;
        s_d     = s_q;
        ah_d    = ah_q;
        am_d    = am_q;
        alarm_d = alarm_q;
        tick_d  = 1'b0;
        err_d   = 1'b0;
        adv     = 1'b0;

        // A load, valid or not, blocks the prescaler and any advance that
        // cycle; only a valid load changes the time.
        if (set_en) begin
            if (set_ok) begin
                h24_d = h24_load;
                m_d   = set_mm;
                s_d   = set_ss;
                pc_d  = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (ena) begin
            if (pc_q == PC_MAX) begin
                pc_d   = '0;
                adv    = 1'b1;
                tick_d = 1'b1;
                h24_d  = h_adv;
                m_d    = m_adv;
                s_d    = s_adv;
            end else begin
                pc_d = pc_q + PC_ONE;
            end
        end

        // Only an advance can trigger; loading the alarm time directly does not.
        match = adv && alm_arm && (h_adv == ah_q) && (m_adv == am_q)
                && (s_adv == 8'h00);

        if (match)
            alarm_d = 1'b1;
        else if (alm_ack || !alm_arm)
            alarm_d = 1'b0;

        if (alm_set) begin
            if (alm_ok) begin
                ah_d = alm_hh;
                am_d = alm_mm;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            h24_q   <= '0;
            m_q     <= '0;
            s_q     <= '0;
            ah_q    <= '0;
            am_q    <= '0;
            alarm_q <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            h24_q   <= h24_d;
            m_q     <= m_d;
            s_q     <= s_d;
            ah_q    <= ah_d;
            am_q    <= am_d;
            alarm_q <= alarm_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        if (mode24)
            hh = h24_q;
        else if (h24_q == 8'h00)
            hh = 8'h12;
        else if (h24_q <= 8'h12)
            hh = h24_q;
        else
            hh = bcd_sub12(h24_q);
    end

    assign pm      = (h24_q >= 8'h12);
    assign mm      = m_q;
    assign ss      = s_q;
    assign tick_1s = tick_q;
    assign alarm   = alarm_q;
    assign set_err = err_q;

endmodule
